// File: rtl/sram_pkg.sv
// Shared types and defaults for the arbitrated SRAM controller slice.
package sram_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;
  localparam int FRAME_WORDS = 7500;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SETUP = 3'd1,
    S_WR_PULSE = 3'd2,
    S_RD_ADDR  = 3'd3,
    S_RD_CAPT  = 3'd4
  } sram_state_e;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } sram_gnt_e;
endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester round-robin arbiter (read vs write) with a last-grant register.
module sram_rr_arb
  import sram_pkg::*;
#(
  parameter int RD_FIRST = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req_rd,
  input  logic i_req_wr,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);
  sram_gnt_e last_gnt;

  // A tie goes to whichever channel lost last time.
  always_comb begin
    o_gnt_rd = 1'b0;
    o_gnt_wr = 1'b0;
    if (i_en) begin
      if (i_req_rd && i_req_wr) begin
        o_gnt_rd = (last_gnt == GNT_WR);
        o_gnt_wr = (last_gnt == GNT_RD);
      end else begin
        o_gnt_rd = i_req_rd;
        o_gnt_wr = i_req_wr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)        last_gnt <= (RD_FIRST != 0) ? GNT_WR : GNT_RD;
    else if (o_gnt_rd) last_gnt <= GNT_RD;
    else if (o_gnt_wr) last_gnt <= GNT_WR;
  end
endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbitrates one write and one read valid/ready channel onto a single async SRAM,
// with byte enables, per-channel frame counters and sticky out-of-range detection.
module sram_arb_ctrl
  import sram_pkg::*;
#(
  parameter  int ADDR_W    = SRAM_ADDR_W,
  parameter  int DATA_W    = SRAM_DATA_W,
  parameter  int DEPTH     = 7500,
  parameter  int FRAME_LEN = FRAME_WORDS,
  parameter  int RD_FIRST  = 1,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [BE_W-1:0]   i_wr_be,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_sram_adr,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_dq_oe,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic [BE_W-1:0]   o_sram_be_n,
  output logic              o_wr_frame_done,
  output logic              o_rd_frame_done,
  output logic              o_err,
  output logic              o_busy
);
  localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  sram_state_e      state;
  logic [BE_W-1:0]  be_r;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic             wr_acc, rd_acc, wr_oor, rd_oor;

  sram_rr_arb #(.RD_FIRST(RD_FIRST)) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (state == S_IDLE),
    .i_req_rd (i_rd_valid),
    .i_req_wr (i_wr_valid),
    .o_gnt_rd (o_rd_ready),
    .o_gnt_wr (o_wr_ready)
  );

  assign wr_acc = i_wr_valid & o_wr_ready;
  assign rd_acc = i_rd_valid & o_rd_ready;
  assign wr_oor = {1'b0, i_wr_addr} >= DEPTH_C;
  assign rd_oor = {1'b0, i_rd_addr} >= DEPTH_C;
  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      o_sram_adr   <= '0;
      o_sram_wdata <= '0;
      be_r         <= '0;
      o_rd_data    <= '0;
      o_rd_valid   <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // Out-of-range requests complete in place and never touch the pins.
          if (wr_acc) begin
            if (wr_oor) o_err <= 1'b1;
            else begin
              o_sram_adr   <= i_wr_addr;
              o_sram_wdata <= i_wr_data;
              be_r         <= i_wr_be;
              state        <= S_WR_SETUP;
            end
          end else if (rd_acc) begin
            if (rd_oor) begin
              o_err      <= 1'b1;
              o_rd_data  <= '0;
              o_rd_valid <= 1'b1;
            end else begin
              o_sram_adr <= i_rd_addr;
              state      <= S_RD_ADDR;
            end
          end
        end
        S_WR_SETUP: state <= S_WR_PULSE;
        S_WR_PULSE: state <= S_IDLE;
        S_RD_ADDR:  state <= S_RD_CAPT;
        S_RD_CAPT: begin
          o_rd_data  <= i_sram_rdata;
          o_rd_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default:    state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      o_wr_frame_done <= 1'b0;
      o_rd_frame_done <= 1'b0;
    end else begin
      o_wr_frame_done <= 1'b0;
      o_rd_frame_done <= 1'b0;
      if (wr_acc) begin
        if (wr_cnt == CNT_LAST) begin
          wr_cnt          <= '0;
          o_wr_frame_done <= 1'b1;
        end else wr_cnt <= wr_cnt + 1'b1;
      end
      if (rd_acc) begin
        if (rd_cnt == CNT_LAST) begin
          rd_cnt          <= '0;
          o_rd_frame_done <= 1'b1;
        end else rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Strobes decode straight from state so an async reset releases the bus at once.
  always_comb begin
    o_sram_ce_n  = 1'b1;
    o_sram_oe_n  = 1'b1;
    o_sram_we_n  = 1'b1;
    o_sram_be_n  = '1;
    o_sram_dq_oe = 1'b0;
    case (state)
      S_WR_SETUP: begin
        o_sram_ce_n  = 1'b0;
        o_sram_dq_oe = 1'b1;
      end
      S_WR_PULSE: begin
        o_sram_ce_n  = 1'b0;
        o_sram_we_n  = 1'b0;
        o_sram_be_n  = ~be_r;
        o_sram_dq_oe = 1'b1;
      end
      S_RD_ADDR, S_RD_CAPT: begin
        o_sram_ce_n = 1'b0;
        o_sram_oe_n = 1'b0;
        o_sram_be_n = '0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Randomised bench for sram_arb_ctrl against a word-array SRAM and golden memory.
module tb_sram_arb_ctrl;
  localparam int AW = 20, DW = 16, BW = 2, DEPTH = 7500, FL = 4;

  logic          i_clk = 1'b0, i_rst = 1'b0;
  logic          i_wr_valid = 1'b0, i_rd_valid = 1'b0;
  logic [AW-1:0] i_wr_addr = '0, i_rd_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic [BW-1:0] i_wr_be = '0;
  logic          o_wr_ready, o_rd_ready, o_rd_valid, o_sram_dq_oe;
  logic          o_sram_ce_n, o_sram_oe_n, o_sram_we_n;
  logic          o_wr_frame_done, o_rd_frame_done, o_err, o_busy;
  logic [DW-1:0] o_rd_data, o_sram_wdata, i_sram_rdata;
  logic [AW-1:0] o_sram_adr;
  logic [BW-1:0] o_sram_be_n;

  int checks = 0, passed = 0;
  int viol = 0, wr_done_cnt = 0, rd_done_cnt = 0;
  int wr_base = 0, rd_base = 0, wr_count = 0, rd_count = 0;
  logic exp_err = 1'b0;
  logic [DW-1:0] sram_mem [0:8191];
  logic [DW-1:0] gold     [0:8191];

  sram_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .FRAME_LEN(FL), .RD_FIRST(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_wr_be(i_wr_be),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_addr(i_rd_addr),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_sram_adr(o_sram_adr), .i_sram_rdata(i_sram_rdata), .o_sram_wdata(o_sram_wdata),
    .o_sram_dq_oe(o_sram_dq_oe), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_we_n(o_sram_we_n), .o_sram_be_n(o_sram_be_n),
    .o_wr_frame_done(o_wr_frame_done), .o_rd_frame_done(o_rd_frame_done),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Async SRAM: combinational read while selected, byte-lane write on the pulse edge.
  assign i_sram_rdata = (!o_sram_ce_n && !o_sram_oe_n) ? sram_mem[o_sram_adr[12:0]] : 16'h0BAD;
  always @(posedge i_clk)
    if (!o_sram_ce_n && !o_sram_we_n && o_sram_dq_oe)
      for (int b = 0; b < BW; b++)
        if (!o_sram_be_n[b]) sram_mem[o_sram_adr[12:0]][b*8 +: 8] <= o_sram_wdata[b*8 +: 8];

  always @(negedge i_clk) begin
    if (!o_sram_we_n && !o_sram_oe_n) viol++;
    if (o_sram_dq_oe && !o_sram_oe_n) viol++;
    if (o_wr_frame_done) wr_done_cnt++;
    if (o_rd_frame_done) rd_done_cnt++;
  end

  task automatic reset_books();
    exp_err = 1'b0; wr_count = 0; rd_count = 0;
    wr_base = wr_done_cnt; rd_base = rd_done_cnt;
  endtask

  task automatic apply_reset();
    @(negedge i_clk); i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    reset_books();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                    output int we_lo, output logic done1, output logic [BW-1:0] pbe_n);
    int n = 0;
    @(negedge i_clk);
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d; i_wr_be = be;
    #1;
    while (!o_wr_ready && n < 50) begin @(negedge i_clk); #1; n++; end
    checks++;
    if (!o_wr_ready) $display("FAIL wr_handshake ready=%0b required 1 (waited %0d)", o_wr_ready, n);
    else passed++;
    @(posedge i_clk); #1;
    i_wr_valid = 1'b0; i_wr_addr = AW'($urandom); i_wr_data = DW'($urandom); i_wr_be = BW'($urandom);
    wr_count++;
    if (int'(a) < DEPTH) begin
      for (int b = 0; b < BW; b++) if (be[b]) gold[a[12:0]][b*8 +: 8] = d[b*8 +: 8];
    end else exp_err = 1'b1;
    we_lo = 0; done1 = 1'b0; pbe_n = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (k == 0) done1 = o_wr_frame_done;
      if (!o_sram_we_n) begin we_lo++; pbe_n = o_sram_be_n; end
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] q, output int lat,
                    output int strobes, output int vcnt);
    int n = 0;
    @(negedge i_clk);
    i_rd_valid = 1'b1; i_rd_addr = a;
    #1;
    while (!o_rd_ready && n < 50) begin @(negedge i_clk); #1; n++; end
    checks++;
    if (!o_rd_ready) $display("FAIL rd_handshake ready=%0b required 1 (waited %0d)", o_rd_ready, n);
    else passed++;
    @(posedge i_clk); #1;
    i_rd_valid = 1'b0; i_rd_addr = AW'($urandom);
    rd_count++;
    if (int'(a) >= DEPTH) exp_err = 1'b1;
    lat = 0; strobes = 0; vcnt = 0; q = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      if (!o_sram_ce_n) strobes++;
      if (o_rd_valid) begin
        vcnt++;
        if (lat == 0) begin lat = k; q = o_rd_data; end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_be_n, o_sram_dq_oe, o_rd_valid,
         o_wr_frame_done, o_rd_frame_done, o_err, o_busy} !== 11'b111_11_000000)
      $display("FAIL reset_ctrl got ce/oe/we/be/oe/v/fd/fd/err/busy=%b required 11111000000",
               {o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_be_n, o_sram_dq_oe, o_rd_valid,
                o_wr_frame_done, o_rd_frame_done, o_err, o_busy});
    else passed++;
    checks++;
    if ({o_sram_adr, o_sram_wdata, o_rd_data} !== '0)
      $display("FAIL reset_data adr=%h wdata=%h rdata=%h required 0", o_sram_adr, o_sram_wdata, o_rd_data);
    else passed++;
    @(negedge i_clk); i_rst = 1'b1;
    reset_books();
  endtask

  task automatic test_write_read();
    int we_lo, lat, st, vc; logic d1; logic [BW-1:0] pb; logic [DW-1:0] q;
    wr(20'd5, 16'hA5A5, 2'b11, we_lo, d1, pb);
    checks++; if (we_lo !== 1) $display("FAIL wr_pulse_len got %0d required 1", we_lo); else passed++;
    rd(20'd5, q, lat, st, vc);
    checks++; if (lat !== 3) $display("FAIL rd_latency got %0d required 3", lat); else passed++;
    checks++; if (q !== 16'hA5A5) $display("FAIL rd_data5 got %h required a5a5", q); else passed++;
    checks++; if (vc !== 1) $display("FAIL rd_valid_pulses got %0d required 1", vc); else passed++;
  endtask

  task automatic test_byte_enable();
    int we_lo, lat, st, vc; logic d1; logic [BW-1:0] pb; logic [DW-1:0] q;
    wr(20'd9, 16'h1234, 2'b11, we_lo, d1, pb);
    wr(20'd9, 16'hFFFF, 2'b01, we_lo, d1, pb);
    checks++; if (pb !== 2'b10) $display("FAIL be_pulse got %b required 10", pb); else passed++;
    rd(20'd9, q, lat, st, vc);
    checks++; if (q !== 16'h12FF) $display("FAIL be_merge got %h required 12ff", q); else passed++;
    wr(20'd9, 16'h0000, 2'b00, we_lo, d1, pb);
    checks++;
    if (we_lo !== 1 || pb !== 2'b11) $display("FAIL be_zero we_lo=%0d be_n=%b required 1/11", we_lo, pb);
    else passed++;
    rd(20'd9, q, lat, st, vc);
    checks++; if (q !== 16'h12FF) $display("FAIL be_zero_data got %h required 12ff", q); else passed++;
  endtask

  task automatic test_tie_rr();
    byte g[$]; int both = 0, bad = 0, nr = 0, nw = 0;
    apply_reset();
    @(negedge i_clk);
    i_wr_valid = 1'b1; i_wr_addr = 20'd20; i_wr_data = 16'h5555; i_wr_be = 2'b11;
    i_rd_valid = 1'b1; i_rd_addr = 20'd21;
    #1;
    for (int c = 0; c < 31; c++) begin
      if (c > 0) begin @(negedge i_clk); #1; end
      if (o_rd_ready && o_wr_ready) both++;
      if (o_rd_ready) begin g.push_back("R"); nr++; end
      if (o_wr_ready) begin g.push_back("W"); nw++; end
    end
    @(posedge i_clk); #1;
    i_wr_valid = 1'b0; i_rd_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    gold[20] = 16'h5555;
    wr_count += nw; rd_count += nr;
    for (int i = 0; i < g.size(); i++) if (g[i] != ((i % 2 == 0) ? "R" : "W")) bad++;
    checks++; if (g.size() < 8) $display("FAIL tie_grants got %0d required >=8", g.size()); else passed++;
    checks++; if (bad != 0) $display("FAIL tie_alternate got %0d out-of-order required 0", bad); else passed++;
    checks++; if (both != 0) $display("FAIL tie_single_grant got %0d double grants required 0", both); else passed++;
  endtask

  task automatic test_oor();
    int lat, st, vc; logic [DW-1:0] q;
    checks++; if (o_err !== exp_err) $display("FAIL oor_pre_err got %b required %b", o_err, exp_err); else passed++;
    rd(AW'(DEPTH), q, lat, st, vc);
    checks++; if (st !== 0) $display("FAIL oor_strobe got %0d strobe cycles required 0", st); else passed++;
    checks++; if (lat !== 1 || q !== '0) $display("FAIL oor_resp lat=%0d data=%h required 1/0000", lat, q); else passed++;
    rd(20'd5, q, lat, st, vc);
    checks++; if (o_err !== 1'b1) $display("FAIL oor_sticky got %b required 1", o_err); else passed++;
    checks++; if (q !== gold[5]) $display("FAIL oor_after_rd got %h required %h", q, gold[5]); else passed++;
  endtask

  task automatic test_frame();
    int we_lo; logic d1; logic [BW-1:0] pb; logic [3:0] dseen;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      wr(AW'(30 + i), DW'($urandom), 2'b11, we_lo, d1, pb);
      dseen[i] = d1;
    end
    checks++; if (dseen !== 4'b1000) $display("FAIL frame_pulse_pos got %b required 1000", dseen); else passed++;
    checks++;
    if (wr_done_cnt - wr_base !== 1) $display("FAIL frame_pulse_cnt got %0d required 1", wr_done_cnt - wr_base);
    else passed++;
    wr(20'd34, 16'h0F0F, 2'b11, we_lo, d1, pb);
    checks++;
    if (d1 !== 1'b0 || wr_done_cnt - wr_base !== 1)
      $display("FAIL frame_restart pulse=%b cnt=%0d required 0/1", d1, wr_done_cnt - wr_base);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0, lat, st, vc, late_v = 0, late_fd = 0; logic [DW-1:0] q;
    @(negedge i_clk);
    i_rd_valid = 1'b1; i_rd_addr = 20'd5;
    #1;
    while (!o_rd_ready && n < 50) begin @(negedge i_clk); #1; n++; end
    @(posedge i_clk); #1;
    i_rd_valid = 1'b0;
    #2 i_rst = 1'b0;
    #1;
    checks++;
    if ({o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_be_n, o_sram_dq_oe, o_busy} !== 7'b1111100)
      $display("FAIL mid_reset_strobes got %b required 1111100",
               {o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_be_n, o_sram_dq_oe, o_busy});
    else passed++;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    reset_books();
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_rd_valid) late_v++;
      if (o_wr_frame_done || o_rd_frame_done) late_fd++;
    end
    checks++;
    if (late_v != 0 || late_fd != 0) $display("FAIL mid_reset_ghost valid=%0d frame_done=%0d required 0/0", late_v, late_fd);
    else passed++;
    rd(20'd5, q, lat, st, vc);
    checks++;
    if (lat !== 3 || q !== gold[5]) $display("FAIL mid_reset_recover lat=%0d data=%h required 3/%h", lat, q, gold[5]);
    else passed++;
  endtask

  task automatic test_random();
    int we_lo, lat, st, vc, bad = 0; logic d1; logic [BW-1:0] pb; logic [DW-1:0] q, exp;
    logic [AW-1:0] a;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + $urandom_range(0, 100)) : AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        wr(a, DW'($urandom), BW'($urandom), we_lo, d1, pb);
        if (we_lo != ((int'(a) < DEPTH) ? 1 : 0)) bad++;
      end else begin
        exp = (int'(a) < DEPTH) ? gold[a[12:0]] : '0;
        rd(a, q, lat, st, vc);
        if (q !== exp || lat != ((int'(a) < DEPTH) ? 3 : 1) || vc != 1) begin
          bad++;
          $display("FAIL rand_read addr=%0d got %h lat %0d required %h", a, q, lat, exp);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    checks++; if (bad != 0) $display("FAIL rand_ops got %0d bad ops required 0", bad); else passed++;
    checks++;
    if (wr_done_cnt - wr_base != wr_count / FL)
      $display("FAIL rand_wr_frames got %0d required %0d", wr_done_cnt - wr_base, wr_count / FL);
    else passed++;
    checks++;
    if (rd_done_cnt - rd_base != rd_count / FL)
      $display("FAIL rand_rd_frames got %0d required %0d", rd_done_cnt - rd_base, rd_count / FL);
    else passed++;
    checks++; if (o_err !== exp_err) $display("FAIL rand_err got %b required %b", o_err, exp_err); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin sram_mem[i] = '0; gold[i] = '0; end
    test_reset();
    test_write_read();
    test_byte_enable();
    test_tie_rr();
    test_oor();
    test_frame();
    test_reset_mid();
    test_random();
    checks++;
    if (viol != 0) $display("FAIL bus_contention got %0d bad cycles required 0", viol); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
Parametrised successor of the single-port SRAM controller. It arbitrates between one write channel (drawing/capture path) and one read channel (display path) onto a single external asynchronous SRAM (IS61WV-class, 16-bit). Both channels use valid/ready handshakes, and the block provides byte enables, per-channel frame counters and out-of-range error detection. It sits between the drawing/VGA logic and the DE2-115 SRAM pins; the top level owns the tri-state DQ buffer.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, SRAM data width; must be a multiple of 8
BE_W, DATA_W/8, byte-enable width (derived, not overridable)
DEPTH, 7500, valid words; addresses >= DEPTH are out of range
FRAME_LEN, 7500, accepted accesses per channel that make one frame; 1..2^ADDR_W
RD_FIRST, 1, on a fresh tie the read channel wins (1) or the write channel wins (0)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_wr_valid  in  1  write request
o_wr_ready  out  1  write accepted this cycle when high with i_wr_valid
i_wr_addr  in  ADDR_W  write word address
i_wr_data  in  DATA_W  write data
i_wr_be  in  BE_W  byte enables, active high; bit k enables byte k
i_rd_valid  in  1  read request
o_rd_ready  out  1  read accepted this cycle when high with i_rd_valid
i_rd_addr  in  ADDR_W  read word address
o_rd_valid  out  1  one-cycle pulse: o_rd_data is valid
o_rd_data  out  DATA_W  read data; holds until the next o_rd_valid
o_sram_adr  out  ADDR_W  SRAM address
i_sram_rdata  in  DATA_W  SRAM DQ input
o_sram_wdata  out  DATA_W  SRAM DQ output value
o_sram_dq_oe  out  1  top level drives DQ with o_sram_wdata when high
o_sram_ce_n  out  1  chip enable, active low
o_sram_oe_n  out  1  output enable, active low
o_sram_we_n  out  1  write enable, active low
o_sram_be_n  out  BE_W  byte lanes, active low (lb/ub when DATA_W=16)
o_wr_frame_done  out  1  pulse when the write frame counter wraps
o_rd_frame_done  out  1  pulse when the read frame counter wraps
o_err  out  1  sticky out-of-range flag
o_busy  out  1  state != S_IDLE

Behaviour:
- Reset values (asynchronous, while i_rst=0):
  - All control outputs inactive: ce_n=1, oe_n=1, we_n=1, be_n all 1.
  - dq_oe=0, o_sram_adr=0, o_sram_wdata=0, o_rd_data=0.
  - o_rd_valid=0, both frame_done=0, o_err=0, both frame counters=0.
  - state=S_IDLE, last_grant=!RD_FIRST (so the first tie goes to the RD_FIRST channel).
- FSM states: S_IDLE, S_WR_SETUP, S_WR_PULSE, S_RD_ADDR, S_RD_CAPT.
- Readies: asserted only in S_IDLE, combinationally from the grant.
  - Only one channel is granted per cycle.
  - Grant: the sole requester wins. On a tie, the channel not granted last time wins (round-robin). RD_FIRST only decides the first tie after reset.
- Accepted write:
  - Register addr, data and be; update last_grant.
  - Go to S_WR_SETUP: ce_n=0, we_n=1, dq_oe=1, address and data stable.
  - Then S_WR_PULSE: we_n=0, be_n=~be, dq_oe=1.
  - Then S_IDLE.
  - Throughput is one write per 3 cycles.
- Accepted read:
  - Go to S_RD_ADDR: ce_n=0, oe_n=0, be_n=0, dq_oe=0.
  - Then S_RD_CAPT: same strobes; i_sram_rdata is registered at the end of this cycle.
  - Then S_IDLE with o_rd_valid=1 for exactly one cycle.
  - Latency from accept to o_rd_valid is 3 cycles.
- Out-of-range request (addr >= DEPTH):
  - Still handshaken and counted in its frame counter.
  - No SRAM access: the FSM stays in S_IDLE, strobes stay inactive, o_err is set (sticky until reset).
  - A read returns o_rd_valid one cycle later with o_rd_data=0.
- i_wr_be=0: full write cycle is issued with all be_n high; no data changes.
- Frame counters: each is $clog2(FRAME_LEN+1) bits.
  - Increments on every accepted request of its channel.
  - At FRAME_LEN-1 it wraps to 0 and the corresponding frame_done pulses in the next cycle.
  - Wrap on write and read in the same cycle cannot happen (only one accept per cycle).
- Request changes while not ready are ignored; no input is latched without a handshake.
- Reset mid-access: strobes deassert immediately (asynchronous). A pending read produces no o_rd_valid, and no partial frame_done is emitted.
- we_n and oe_n are never low in the same cycle. dq_oe=1 only in the write states.

Decomposition:
- Package sram_pkg holds:
  - The state enum (sram_state_e).
  - The grant enum (GNT_RD, GNT_WR).
  - Default constants SRAM_ADDR_W, SRAM_DATA_W, FRAME_WORDS=7500.
- One sub-module: sram_rr_arb, a 2-requester round-robin arbiter with an enable input and last-grant register.
- Frame counters stay inline.

Test Plan:
- Write addr 5, data 16'hA5A5, be=2'b11, then read addr 5 -> we_n low exactly 1 cycle in S_WR_PULSE; o_rd_valid 3 cycles after read accept with 16'hA5A5.
- Write 16'h1234 to addr 9, then 16'hFFFF with be=2'b01, then read addr 9 -> o_sram_be_n=2'b10 during the pulse; read returns 16'h12FF.
- i_wr_valid and i_rd_valid held high continuously from reset, RD_FIRST=1 -> grants alternate R,W,R,W; neither channel is starved; no cycle has we_n=0 and oe_n=0 together.
- Read addr 7500 with DEPTH=7500 -> no SRAM strobe; o_err=1 and stays high; o_rd_valid next cycle with data 0.
- FRAME_LEN=4, 4 writes accepted -> o_wr_frame_done pulses once, the cycle after the 4th accept; the 5th write starts a new frame.
- i_rst low during S_RD_ADDR -> all strobes high immediately; no o_rd_valid afterwards; next request after reset behaves normally.
